sumador_serie_arbitro: RTL and testbench

//  Bit-serial N-bit adder shared by two requesters under round-robin arbitration.
//  One full-adder slice plus a carry flop processes one operand bit per clock, LSB first.
//  The block sequences the slice, latches operands, counts bits and returns sum and carry-out.
//  It sits between two client blocks and the shared adder resource. It replaces N parallel

---
 rtl/sumador_serie_arbitro.sv | 124 ++++++++++++
 tb/tb_sumador_serie_arbitro.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sumador_serie_arbitro.sv
// Bit-serial N-bit adder shared by two requesters under round-robin arbitration.
// One full-adder slice and a carry flop consume one operand bit per clock, LSB first.
module sumador_serie_arbitro #(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_i,
  input  logic [N-1:0] a0_i,
  input  logic [N-1:0] b0_i,
  input  logic         req1_i,
  input  logic [N-1:0] a1_i,
  input  logic [N-1:0] b1_i,
  output logic [1:0]   gnt_o,
  output logic         busy_o,
  output logic         owner_o,
  output logic         done_o,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [N-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          s_bit, carry_nxt, win;

  assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = 2'b00;
    owner_d = owner_q;
    last_d  = last_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    c_d     = c_q;
    win     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // On contention the requester not served last time wins.
          win     = (req0_i && req1_i) ? ~last_q : req1_i;
          a_d     = win ? a1_i : a0_i;
          b_d     = win ? b1_i : b0_i;
          carry_d = 1'b0;
          cnt_d   = '0;
          owner_d = win;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = StRun;
        end
      end
      StRun: begin
        carry_d = carry_nxt;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {s_bit, sum_q[N-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          s_d     = {s_bit, sum_q[N-1:1]};
          c_d     = carry_nxt;
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StFin);
  assign owner_o = owner_q;
  assign s_o     = s_q;
  assign c_o     = c_q;

endmodule

// File: tb/tb_sumador_serie_arbitro.sv
// Directed bench for sumador_serie_arbitro: an N=8 instance and an N=2 instance.
module tb_sumador_serie_arbitro;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] gnt;
  logic       busy, owner, done, c;
  logic [7:0] s;

  logic       req0_n2 = 1'b0;
  logic [1:0] a_n2 = '0, b_n2 = '0;
  logic [1:0] gnt_n2;
  logic       busy_n2, owner_n2, done_n2, c_n2;
  logic [1:0] s_n2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_serie_arbitro #(.N(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .a0_i(a0), .b0_i(b0),
    .req1_i(req1), .a1_i(a1), .b1_i(b1),
    .gnt_o(gnt), .busy_o(busy), .owner_o(owner), .done_o(done), .s_o(s), .c_o(c)
  );

  sumador_serie_arbitro #(.N(2)) u_dut_n2 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0_n2), .a0_i(a_n2), .b0_i(b_n2),
    .req1_i(1'b0), .a1_i(2'b00), .b1_i(2'b00),
    .gnt_o(gnt_n2), .busy_o(busy_n2), .owner_o(owner_n2), .done_o(done_n2),
    .s_o(s_n2), .c_o(c_n2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the GNT cycle (cycle 1); returns in the IDLE cycle after DONE.
  task automatic wait_done(input string tag, input int exp_cyc, input logic [7:0] exp_s,
                           input logic exp_c, input logic exp_own);
    int cyc = 1;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    check_eq({tag, "_done_cyc"}, cyc, exp_cyc);
    check_eq({tag, "_s"}, s, exp_s);
    check_eq({tag, "_c"}, c, exp_c);
    check_eq({tag, "_owner"}, owner, exp_own);
    step();
  endtask

  task automatic do_op(input string tag, input logic r0, input logic r1,
                       input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1,
                       input logic [1:0] exp_gnt, input logic [7:0] exp_s, input logic exp_c);
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    step();
    check_eq({tag, "_gnt"}, gnt, exp_gnt);
    check_eq({tag, "_busy"}, busy, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    wait_done(tag, 9, exp_s, exp_c, exp_gnt[1]);
  endtask

  initial begin
    int g, d, cyc, overlap;
    logic exp_own;

    // Reset state
    step(); step();
    rst = 1'b0;
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_s", s, 8'd0);
    check_eq("rst_c", c, 1'b0);

    // 1 and 2: single requesters
    do_op("t1", 1'b1, 1'b0, 8'd3, 8'd5, 8'd0, 8'd0, 2'b01, 8'd8, 1'b0);
    do_op("t2a", 1'b0, 1'b1, 8'd0, 8'd0, 8'd255, 8'd1, 2'b10, 8'd0, 1'b1);
    do_op("t2b", 1'b0, 1'b1, 8'd0, 8'd0, 8'd200, 8'd100, 2'b10, 8'd44, 1'b1);

    // 3: both held continuously after reset -> 0,1,0,1
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    req1 = 1'b1; a1 = 8'hF0; b1 = 8'h20;
    g = 0; d = 0; cyc = 0; overlap = 0; exp_own = 1'b0;
    while (d < 4 && cyc < 80) begin
      step();
      cyc++;
      if (gnt != 2'b00 && done) overlap++;
      if (gnt != 2'b00 && g < 4) begin
        exp_own = g[0];
        check_eq($sformatf("t3_gnt%0d", g), gnt, exp_own ? 2'b10 : 2'b01);
        g++;
      end
      if (done) begin
        check_eq($sformatf("t3_owner%0d", d), owner, exp_own);
        check_eq($sformatf("t3_s%0d", d), s, exp_own ? 8'h10 : 8'h46);
        check_eq($sformatf("t3_c%0d", d), c, exp_own);
        d++;
      end
    end
    check_eq("t3_dones", d, 4);
    check_eq("t3_gnt_done_overlap", overlap, 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (12) step();

    // 4: reset in RUN cycle 4 aborts the operation
    req0 = 1'b1; a0 = 8'd100; b0 = 8'd27;
    step();
    check_eq("t4_gnt", gnt, 2'b01);
    req0 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t4_rst_out", {gnt, busy, done, owner, s, c}, 14'd0);
    d = 0;
    repeat (12) begin
      step();
      if (done) d++;
    end
    check_eq("t4_no_done", d, 0);
    do_op("t4b", 1'b1, 1'b0, 8'd100, 8'd27, 8'd0, 8'd0, 2'b01, 8'd127, 1'b0);

    // 5: REQ0 withdrawn before the sampling edge; operand change after GNT ignored
    req0 = 1'b1; req1 = 1'b1; a0 = 8'd1; b0 = 8'd1; a1 = 8'h80; b1 = 8'h80;
    #3 req0 = 1'b0;
    step();
    check_eq("t5_gnt", gnt, 2'b10);
    req1 = 1'b0; a1 = 8'd1; b1 = 8'd1;
    wait_done("t5", 9, 8'd0, 1'b1, 1'b1);

    // 6: N=2 exhaustive
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        req0_n2 = 1'b1; a_n2 = 2'(x); b_n2 = 2'(y);
        step();
        check_eq($sformatf("t6_gnt_%0d_%0d", x, y), gnt_n2, 2'b01);
        req0_n2 = 1'b0;
        cyc = 1;
        while (!done_n2 && cyc < 20) begin
          step();
          cyc++;
        end
        check_eq($sformatf("t6_cyc_%0d_%0d", x, y), cyc, 3);
        check_eq($sformatf("t6_sum_%0d_%0d", x, y), {c_n2, s_n2}, x + y);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
